// File: rtl/fc_pkg.sv
// Shared defaults and bias word types for the fully-connected datapath.
package fc_pkg;

    localparam int FC_DATA_WIDTH = 16;
    localparam int FC_DEPTH      = 64;
    localparam int FC_BATCH_SIZE = 16;

    typedef logic [FC_DATA_WIDTH-1:0] bias_t;
    typedef bias_t [FC_BATCH_SIZE-1:0] bias_batch_t;

    // Width of a counter holding values 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_batch_buffer_if.sv
// Loader-side write handshake and MAC-side batch handshake of the bias buffer.
interface bias_batch_buffer_if #(
    parameter int DATA_WIDTH = fc_pkg::FC_DATA_WIDTH,
    parameter int BATCH_SIZE = fc_pkg::FC_BATCH_SIZE
);

    logic                                 wr_valid;
    logic                                 wr_ready;
    logic [DATA_WIDTH-1:0]                wr_data;
    logic                                 rd_ready;
    logic                                 rd_valid;
    logic [BATCH_SIZE-1:0][DATA_WIDTH-1:0] rd_data;

    // The buffer is the slave; the loader/consumer pair is the master.
    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/bias_ring_ctrl.sv
// Pointer, occupancy and flag bookkeeping for the circular bias store.
// With BIAS_BUF_REPLAY_EN the batch_off register lets fetches reuse the stored table.
module bias_ring_ctrl
    import fc_pkg::*;
#(
    parameter int DEPTH      = FC_DEPTH,
    parameter int BATCH_SIZE = FC_BATCH_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_valid,
    input  logic                     rd_ready,
`ifdef BIAS_BUF_REPLAY_EN
    input  logic                     replay_en,
`endif
    output logic                     wr_ready,
    output logic                     wr_en,
    output logic                     fetch,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] fetch_base,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          consume;

    // Reset and clear both suppress any write or fetch in their cycle.
    assign wr_ready = ~full;
    assign wr_en    = reset & ~clear & wr_valid & ~full;
    assign fetch    = reset & ~clear & (count >= CW'(BATCH_SIZE)) & (~rd_valid | rd_ready);

`ifdef BIAS_BUF_REPLAY_EN
    localparam int OW = clog2_min1(DEPTH / BATCH_SIZE);

    logic [OW-1:0] batch_off;
    logic          replay_q;
    logic [CW-1:0] batches;
    logic          last_batch;

    assign consume    = fetch & ~replay_en;
    assign fetch_base = rd_ptr + AW'(batch_off * BATCH_SIZE);
    assign batches    = count >> $clog2(BATCH_SIZE);
    assign last_batch = (CW'(batch_off) + CW'(1)) >= batches;

    // Offset walks through the stored batches and restarts when replay drops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            batch_off <= '0;
            replay_q  <= 1'b0;
        end else begin
            replay_q <= replay_en;
            if (clear || (replay_q && !replay_en)) begin
                batch_off <= '0;
            end else if (fetch && replay_en) begin
                batch_off <= last_batch ? '0 : batch_off + OW'(1);
            end
        end
    end
`else
    assign consume    = fetch;
    assign fetch_base = rd_ptr;
`endif

    assign count_next = count + CW'(wr_en) - (consume ? CW'(BATCH_SIZE) : '0);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (consume) begin
                rd_ptr <= rd_ptr + AW'(BATCH_SIZE);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
            if (fetch) begin
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bias_batch_buffer.sv
// Circular bias store: one word in per cycle, one registered batch out per accepted transfer.
// Optional replay of the stored table is enabled by defining BIAS_BUF_REPLAY_EN.
module bias_batch_buffer
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int DEPTH      = FC_DEPTH,
    parameter int BATCH_SIZE = FC_BATCH_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    bias_batch_buffer_if.slave     bus,
`ifdef BIAS_BUF_REPLAY_EN
    input  logic                   replay_en,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic                  wr_en;
    logic                  fetch;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         fetch_base;

    bias_ring_ctrl #(
        .DEPTH      (DEPTH),
        .BATCH_SIZE (BATCH_SIZE)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .wr_valid   (bus.wr_valid),
        .rd_ready   (bus.rd_ready),
`ifdef BIAS_BUF_REPLAY_EN
        .replay_en  (replay_en),
`endif
        .wr_ready   (bus.wr_ready),
        .wr_en      (wr_en),
        .fetch      (fetch),
        .wr_ptr     (wr_ptr),
        .fetch_base (fetch_base),
        .rd_valid   (bus.rd_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    // Storage is deliberately left unreset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr] <= bus.wr_data;
        end
    end

    // Element i of the batch is the i-th oldest word, wrapping around the ring.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.rd_data <= '0;
        end else if (fetch) begin
            for (int i = 0; i < BATCH_SIZE; i++) begin
                bus.rd_data[i] <= ram[fetch_base + AW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_bias_batch_buffer.sv
// Directed self-checking bench for bias_batch_buffer with a small occupancy/data scoreboard.
// Replay scenario is exercised only when BIAS_BUF_REPLAY_EN is defined.
module tb_bias_batch_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 64;
    localparam int B     = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       replay_sig;
    logic [6:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    int               m_count;
    bit               m_valid;
    bit               m_ovf;
    bit               m_prev;
    int               m_off;
    logic [15:0]      q [$];
    logic [B*DW-1:0]  m_out;

    always #5 clk = ~clk;

    bias_batch_buffer_if #(.DATA_WIDTH(DW), .BATCH_SIZE(B)) bus ();

    bias_batch_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .BATCH_SIZE (B)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .bus       (bus),
`ifdef BIAS_BUF_REPLAY_EN
        .replay_en (replay_sig),
`endif
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the scoreboard state.
    task automatic checkAll();
        checkOutput("count", count, m_count);
        checkOutput("rd_valid", bus.rd_valid, m_valid);
        checkOutput("rd_data", bus.rd_data, m_out);
        checkOutput("full", full, m_count == DEPTH);
        checkOutput("empty", empty, m_count == 0);
        checkOutput("overflow", overflow, m_ovf);
        checkOutput("wr_ready", bus.wr_ready, m_count != DEPTH);
    endtask

    task automatic applyStimulus(input bit wv, input logic [15:0] wd, input bit rr);
        bit acc;
        bit fet;
        int nb;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        acc = wv && (m_count != DEPTH);
        if (wv && m_count == DEPTH) m_ovf = 1'b1;
        if (m_prev && !replay_sig) m_off = 0;
        fet = (m_count >= B) && (!m_valid || rr);
        if (fet) begin
            if (replay_sig) begin
                for (int i = 0; i < B; i++) m_out[i*DW +: DW] = q[m_off*B + i];
                nb = m_count / B;
                m_off = (m_off + 1 >= nb) ? 0 : m_off + 1;
            end else begin
                for (int i = 0; i < B; i++) m_out[i*DW +: DW] = q.pop_front();
                m_count -= B;
            end
            m_valid = 1'b1;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        if (acc) begin
            q.push_back(wd);
            m_count++;
        end
        m_prev = replay_sig;
        @(posedge clk);
        #1;
        checkAll();
    endtask

    // Reset pulse taken while a write and a read are being offered.
    task automatic doReset();
        reset        = 1'b0;
        clear        = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hFFFF;
        bus.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b1;
        m_count = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_prev  = 1'b0;
        m_off   = 0;
        m_out   = '0;
        q.delete();
        checkAll();
    endtask

    task automatic doClear(input bit wv, input logic [15:0] wd, input bit rr);
        clear        = 1'b1;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        m_count = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_off   = 0;
        m_prev  = replay_sig;
        q.delete();
        checkAll();
    endtask

    initial begin
        reset        = 1'b0;
        clear        = 1'b0;
        replay_sig   = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;

        // First batch arrives one cycle after the 16th write.
        doReset();
        checkOutput("rst_empty", empty, 1'b1);
        for (int k = 1; k <= 16; k++) applyStimulus(1'b1, 16'(k), 1'b0);
        checkOutput("t1_count16", count, 7'd16);
        checkOutput("t1_not_yet_valid", bus.rd_valid, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("t1_valid", bus.rd_valid, 1'b1);
        checkOutput("t1_elem0", bus.rd_data[0], 16'h0001);
        checkOutput("t1_elem15", bus.rd_data[15], 16'h0010);
        checkOutput("t1_count0", count, 7'd0);

        // Fill to full with the first batch parked, then overflow and drain.
        doReset();
        for (int k = 0; k < 80; k++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(k), 1'b0);
            if (k >= 20 && k < 25) begin
                checkOutput("t2_hold_elem0", bus.rd_data[0], 16'h0100);
                checkOutput("t2_hold_elem15", bus.rd_data[15], 16'h010F);
            end
        end
        checkOutput("t2_full", full, 1'b1);
        checkOutput("t2_wr_ready", bus.wr_ready, 1'b0);
        checkOutput("t2_count64", count, 7'd64);
        applyStimulus(1'b1, 16'hDEAD, 1'b0);
        checkOutput("t2_overflow", overflow, 1'b1);
        checkOutput("t2_count_kept", count, 7'd64);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b0, 16'h0, 1'b1);
            checkOutput("t2_batch_elem0", bus.rd_data[0], 16'h0110 + 16'(16*n));
            checkOutput("t2_batch_count", count, 7'(48 - 16*n));
        end
        checkOutput("t2_empty", empty, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("t2_valid_drop", bus.rd_valid, 1'b0);
        checkOutput("t2_data_held", bus.rd_data[0], 16'h0140);

        // Clear beats a same-cycle write; then stream across the pointer wrap.
        doClear(1'b1, 16'hBEEF, 1'b0);
        checkOutput("t3_clear_ovf", overflow, 1'b0);
        checkOutput("t3_clear_count", count, 7'd0);
        for (int k = 0; k < 56; k++) applyStimulus(1'b1, 16'h0300 + 16'(k), 1'b0);
        checkOutput("t3_count40", count, 7'd40);
        for (int k = 0; k < 70; k++) applyStimulus(1'b1, 16'h0400 + 16'(k), 1'b1);
        doClear(1'b1, 16'hBEEF, 1'b1);
        checkOutput("t3_mid_clear_valid", bus.rd_valid, 1'b0);
        checkOutput("t3_mid_clear_count", count, 7'd0);

        // Output stays frozen while the consumer stalls, then a reset mid-transfer.
        for (int k = 0; k < 22; k++) begin
            applyStimulus(1'b1, 16'h0500 + 16'(k), 1'b0);
            if (k >= 17) checkOutput("t4_stall_elem0", bus.rd_data[0], 16'h0500);
        end
        doReset();
        checkOutput("t4_rst_count", count, 7'd0);
        checkOutput("t4_rst_valid", bus.rd_valid, 1'b0);
        checkOutput("t4_rst_data", bus.rd_data, 256'h0);
        checkOutput("t4_rst_full", full, 1'b0);
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 16'h0600 + 16'(k), 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("t4_resume_elem0", bus.rd_data[0], 16'h0600);

`ifdef BIAS_BUF_REPLAY_EN
        // Two stored batches replay alternately without being consumed.
        doReset();
        replay_sig = 1'b1;
        for (int k = 0; k < 32; k++) applyStimulus(1'b1, 16'h0200 + 16'(k), 1'b0);
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b0, 16'h0, 1'b1);
            checkOutput("t5_replay_elem0", bus.rd_data[0], (n % 2 == 1) ? 16'h0210 : 16'h0200);
            checkOutput("t5_replay_count", count, 7'd32);
        end
        replay_sig = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("t5_consume_count", count, 7'd16);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
